// File: rtl/memoria.sv
// Dual-read, single-write register file backing the stack unit.
// Optional write-through bypass: define MEMORIA_WRITE_FORWARD_EN.
module memoria #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 1024,
    parameter int AWIDTH = 10
) (
    output logic [WIDTH-1:0]  out1,
    output logic [WIDTH-1:0]  out2,
    input  logic [WIDTH-1:0]  x,
    input  logic [AWIDTH-1:0] ind1,
    input  logic [AWIDTH-1:0] ind2,
    input  logic              clock,
    input  logic              beta,
    input  logic              reset
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Reset clears the whole array in one edge and takes priority over a write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (beta) begin
            mem_q[ind1] <= x;
        end
    end

`ifdef MEMORIA_WRITE_FORWARD_EN
    logic fwd;
    assign fwd = beta && !reset;

    always_comb begin
        out1 = fwd ? x : mem_q[ind1];
        out2 = (fwd && (ind2 == ind1)) ? x : mem_q[ind2];
    end
`else
    always_comb begin
        out1 = mem_q[ind1];
        out2 = mem_q[ind2];
    end
`endif

endmodule

// File: tb/tb_memoria.sv
// Self-checking bench for memoria: directed cases plus randomized traffic
// checked against an array model of the memory.
module tb_memoria;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 1024;
    localparam int AWIDTH = 10;

    logic [WIDTH-1:0]  out1, out2, x;
    logic [AWIDTH-1:0] ind1, ind2;
    logic              clock, beta, reset;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] model [DEPTH];

    memoria #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AWIDTH(AWIDTH)) dut (
        .out1 (out1),
        .out2 (out2),
        .x    (x),
        .ind1 (ind1),
        .ind2 (ind2),
        .clock(clock),
        .beta (beta),
        .reset(reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock edge; the model follows the inputs held across that edge.
    task automatic tick();
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else if (beta) begin
            model[ind1] = x;
        end
        #1;
    endtask

    function automatic logic [WIDTH-1:0] exp1();
`ifdef MEMORIA_WRITE_FORWARD_EN
        if (beta && !reset) return x;
`endif
        return model[ind1];
    endfunction

    function automatic logic [WIDTH-1:0] exp2();
`ifdef MEMORIA_WRITE_FORWARD_EN
        if (beta && !reset && ind2 == ind1) return x;
`endif
        return model[ind2];
    endfunction

    task automatic test_reset();
        reset = 1'b1; beta = 1'b0; x = '0; ind1 = '0; ind2 = '0;
        tick();
        reset = 1'b0; ind1 = 10'd0; ind2 = 10'd1023;
        #1;
        checks++;
        if (out1 !== 32'd0) begin
            errors++; $display("FAIL reset_out1 got=%h exp=%h", out1, 32'd0);
        end
        checks++;
        if (out2 !== 32'd0) begin
            errors++; $display("FAIL reset_out2 got=%h exp=%h", out2, 32'd0);
        end
        for (int k = 0; k < 8; k++) begin
            ind1 = 10'($urandom_range(0, DEPTH-1));
            ind2 = 10'($urandom_range(0, DEPTH-1));
            #1;
            checks++;
            if (out1 !== 32'd0 || out2 !== 32'd0) begin
                errors++;
                $display("FAIL reset_rand a1=%0d a2=%0d got=%h/%h exp=0/0", ind1, ind2, out1, out2);
            end
        end
    endtask

    task automatic test_write_read();
        beta = 1'b1; x = 32'd42; ind1 = 10'd0; ind2 = 10'd0;
        tick();
        beta = 1'b0; #1;
        checks++;
        if (out1 !== 32'd42 || out2 !== 32'd42) begin
            errors++; $display("FAIL write42 got=%0d/%0d exp=42/42", out1, out2);
        end
        beta = 1'b1; x = 32'd128; ind1 = 10'd0; ind2 = 10'd1023;
        tick();
        beta = 1'b0; #1;
        checks++;
        if (out1 !== 32'd128 || out2 !== 32'd0) begin
            errors++; $display("FAIL write128 got=%0d/%0d exp=128/0", out1, out2);
        end
        beta = 1'b1; x = 32'd256; ind1 = 10'd1023;
        tick();
        beta = 1'b0; #1;
        checks++;
        if (out1 !== 32'd256 || out2 !== 32'd256) begin
            errors++; $display("FAIL write256_top got=%0d/%0d exp=256/256", out1, out2);
        end
    endtask

    task automatic test_no_write();
        beta = 1'b0; x = 32'd99; ind1 = 10'd5; ind2 = 10'd5;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (out1 !== 32'd0 || out2 !== 32'd0) begin
            errors++; $display("FAIL no_write got=%0d/%0d exp=0/0", out1, out2);
        end
    endtask

    task automatic test_reset_priority();
        beta = 1'b1; x = 32'd7; ind1 = 10'd3; ind2 = 10'd0;
        tick();
        beta = 1'b0; #1;
        checks++;
        if (out1 !== 32'd7) begin
            errors++; $display("FAIL pre_reset_write got=%0d exp=7", out1);
        end
        reset = 1'b1; beta = 1'b1; x = 32'd9; ind1 = 10'd3;
        tick();
        reset = 1'b0; beta = 1'b0; #1;
        checks++;
        if (out1 !== 32'd0 || out2 !== 32'd0) begin
            errors++; $display("FAIL reset_priority got=%0d/%0d exp=0/0", out1, out2);
        end
        ind1 = 10'd1023; #1;
        checks++;
        if (out1 !== 32'd0) begin
            errors++; $display("FAIL reset_clears_top got=%0d exp=0", out1);
        end
    endtask

    task automatic test_read_during_write();
        logic [WIDTH-1:0] pre;
        beta = 1'b1; x = 32'd55; ind1 = 10'd10; ind2 = 10'd10;
        #1;
`ifdef MEMORIA_WRITE_FORWARD_EN
        pre = 32'd55;
`else
        pre = 32'd0;
`endif
        checks++;
        if (out1 !== pre || out2 !== pre) begin
            errors++; $display("FAIL rdw_before got=%0d/%0d exp=%0d/%0d", out1, out2, pre, pre);
        end
        tick();
        beta = 1'b0; #1;
        checks++;
        if (out1 !== 32'd55 || out2 !== 32'd55) begin
            errors++; $display("FAIL rdw_after got=%0d/%0d exp=55/55", out1, out2);
        end
    endtask

    function automatic logic [AWIDTH-1:0] pick_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 10'd0;
        if (r == 1) return 10'd1023;
        if (r < 6)  return 10'($urandom_range(0, 7));
        return 10'($urandom_range(0, DEPTH-1));
    endfunction

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            ind1 = pick_addr();
            ind2 = ($urandom_range(0, 3) == 0) ? ind1 : pick_addr();
            x    = $urandom;
            beta = ($urandom_range(0, 2) != 0);
            #1;
            checks++;
            if (out1 !== exp1() || out2 !== exp2()) begin
                errors++;
                $display("FAIL rand_pre it=%0d a1=%0d a2=%0d we=%0b got=%h/%h exp=%h/%h",
                         k, ind1, ind2, beta, out1, out2, exp1(), exp2());
            end
            tick();
            beta = 1'b0; #1;
            checks++;
            if (out1 !== model[ind1] || out2 !== model[ind2]) begin
                errors++;
                $display("FAIL rand_post it=%0d a1=%0d a2=%0d got=%h/%h exp=%h/%h",
                         k, ind1, ind2, out1, out2, model[ind1], model[ind2]);
            end
        end
    endtask

    initial begin
        reset = 1'b0; beta = 1'b0; x = '0; ind1 = '0; ind2 = '0;
        @(negedge clock);
        test_reset();
        test_write_read();
        test_no_write();
        test_reset_priority();
        test_read_during_write();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
